// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative RV32M-style multiply/divide unit, one bit per cycle
// Magnitudes are iterated; sign correction happens in a single FIX cycle.
module mul_div_unit #(
  parameter int XLEN      = 32,
  parameter int EARLY_OUT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [2:0]      r_op;
  logic            r_neg;
  logic            r_rem_neg;
  logic            r_dz;
  logic [XLEN:0]   r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_opnd;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_result;

  logic            w_is_div;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic [XLEN-1:0] w_int_min;
  logic            w_b_zero;
  logic            w_ovf;
  logic            w_early;
  logic            w_accept;
  logic [XLEN-1:0] w_early_res;

  assign w_is_div   = op[2];
  assign w_a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  assign w_b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign w_a_neg    = w_a_signed && a[XLEN-1];
  assign w_b_neg    = w_b_signed && b[XLEN-1];
  assign w_a_mag    = w_a_neg ? -a : a;
  assign w_b_mag    = w_b_neg ? -b : b;
  assign w_int_min  = {1'b1, {(XLEN-1){1'b0}}};
  assign w_b_zero   = (b == '0);
  assign w_ovf      = ((op == OP_DIV) || (op == OP_REM)) && (a == w_int_min) && (b == '1);
  assign w_early    = (EARLY_OUT != 0) && w_is_div && (w_b_zero || w_ovf);
  assign w_accept   = in_valid && (r_state == S_IDLE) && !flush;

  // op[1] selects the remainder among the divide ops
  assign w_early_res = w_b_zero ? (op[1] ? a : '1) : (op[1] ? '0 : w_int_min);

  // Multiply step: conditional add into the upper half, then shift right.
  logic [XLEN:0]   w_add_sum;
  assign w_add_sum = r_hi + {1'b0, (r_lo[0] ? r_opnd : '0)};

  // Divide step: shift next dividend bit in, keep the trial difference if non-negative.
  logic [XLEN:0]   w_shift;
  logic [XLEN+1:0] w_trial;
  logic            w_qbit;
  assign w_shift = {r_hi[XLEN-1:0], r_lo[XLEN-1]};
  assign w_trial = {1'b0, w_shift} - {2'b00, r_opnd};
  assign w_qbit  = !w_trial[XLEN+1];

  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_res;

  assign w_prod   = {r_hi[XLEN-1:0], r_lo};
  assign w_prod_s = r_neg ? -w_prod : w_prod;
  assign w_quo    = r_dz ? '1 : (r_neg ? -r_lo : r_lo);
  assign w_rem    = r_rem_neg ? -r_hi[XLEN-1:0] : r_hi[XLEN-1:0];

  always_comb begin
    w_fix_res = w_rem;
    case (r_op)
      OP_MUL:                       w_fix_res = w_prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_fix_res = w_prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              w_fix_res = w_quo;
      default:                      w_fix_res = w_rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (w_accept) begin
          w_state_next = w_early ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_count == '0) begin
          w_state_next = S_FIX;
        end
      end
      S_FIX: begin
        w_state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    // A pipeline kill overrides every other transition, including a completing handshake
    if (flush) begin
      w_state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= '0;
      r_neg     <= 1'b0;
      r_rem_neg <= 1'b0;
      r_dz      <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_opnd    <= '0;
      r_count   <= '0;
      r_result  <= '0;
    end else if (w_accept) begin
      r_op      <= op;
      r_neg     <= w_a_neg ^ w_b_neg;
      r_rem_neg <= w_a_neg;
      r_dz      <= w_is_div && w_b_zero;
      r_hi      <= '0;
      r_lo      <= w_is_div ? w_a_mag : w_b_mag;
      r_opnd    <= w_is_div ? w_b_mag : w_a_mag;
      r_count   <= CW'(XLEN - 1);
      if (w_early) begin
        r_result <= w_early_res;
      end
    end else if (!flush) begin
      if (r_state == S_BUSY) begin
        if (r_op[2]) begin
          r_hi <= w_qbit ? w_trial[XLEN:0] : w_shift;
          r_lo <= {r_lo[XLEN-2:0], w_qbit};
        end else begin
          r_hi <= {1'b0, w_add_sum[XLEN:1]};
          r_lo <= {w_add_sum[0], r_lo[XLEN-1:1]};
        end
        if (r_count != '0) begin
          r_count <= r_count - CW'(1);
        end
      end
      if (r_state == S_FIX) begin
        r_result <= w_fix_res;
      end
    end
  end

  assign result = r_result;

endmodule
